sample_deser: RTL and testbench

Serial-to-parallel deserializer for the STA sample designs. Collects framed serial bits into WIDTH-bit words and hands them downstream over a valid/ready handshake with one word of buffering. Every state element is a reset-only flop, so the block can be built either behaviourally or from `dffrx1` library cells. All outputs are registered or decoded from registered state; no input-to-output combinational path exists.

---
 rtl/sample_deser.sv | 142 ++++++++++++++
 tb/tb_sample_deser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_deser.sv
// Serial-to-parallel deserializer: framed serial bits into WIDTH-bit words with one word of output buffering.
// Define SAMPLE_DESER_CELLS_EN to build every flop from dffrx1 library cells instead of behavioural registers.
module sample_deser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             RB,
  input  logic             SI,
  input  logic             SV,
  input  logic             SYNC,
  output logic             SRDY,
  output logic [WIDTH-1:0] PO,
  output logic             PV,
  input  logic             PR,
  output logic             FERR
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned NFF = 2 * WIDTH + CW + 4;

  // IDLE encodes as zero so every flop resets to 0
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    STALL = 2'b10
  } state_t;

  // Flop vector layout: {sh, PO, cnt, PV, FERR, state}
  logic [NFF-1:0]   w_d;
  logic [NFF-1:0]   r_q;

  state_t           w_state;
  logic [CW-1:0]    w_cnt;
  logic [WIDTH-1:0] w_sh;

  state_t           w_state_n;
  logic [CW-1:0]    w_cnt_n;
  logic [WIDTH-1:0] w_sh_n;
  logic [WIDTH-1:0] w_po_n;
  logic             w_pv_n;
  logic             w_ferr_n;

  logic             w_accept;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;

  assign w_state = state_t'(r_q[1:0]);
  assign FERR    = r_q[2];
  assign PV      = r_q[3];
  assign w_cnt   = r_q[4 +: CW];
  assign PO      = r_q[4 + CW +: WIDTH];
  assign w_sh    = r_q[4 + CW + WIDTH +: WIDTH];

  assign SRDY     = (w_state != STALL);
  assign w_accept = SV && (w_state != STALL);

  // A SYNC bit starts from an empty register so the old partial word is discarded
  always_comb begin
    w_base = SYNC ? '0 : w_sh;
    if (MSB_FIRST) begin
      w_shifted = {w_base[WIDTH-2:0], SI};
    end else begin
      w_shifted = {SI, w_base[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_n = w_state;
    w_cnt_n   = w_cnt;
    w_sh_n    = w_sh;
    w_po_n    = PO;
    w_pv_n    = PV;
    w_ferr_n  = 1'b0;

    if (PV && PR) begin
      w_pv_n = 1'b0;
    end

    case (w_state)
      IDLE: begin
        if (w_accept && SYNC) begin
          w_sh_n    = w_shifted;
          w_cnt_n   = CW'(1);
          w_state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (w_accept) begin
          w_sh_n   = w_shifted;
          w_ferr_n = SYNC && (w_cnt != '0);
          if (SYNC) begin
            w_cnt_n = CW'(1);
          end else if (w_cnt == CW'(WIDTH - 1)) begin
            w_cnt_n = '0;
            if (!PV || PR) begin
              w_po_n = w_shifted;
              w_pv_n = 1'b1;
            end else begin
              w_state_n = STALL;
            end
          end else begin
            w_cnt_n = w_cnt + CW'(1);
          end
        end
      end
      STALL: begin
        // Completed word waits in sh until the output register drains
        if (PR) begin
          w_po_n    = w_sh;
          w_pv_n    = 1'b1;
          w_state_n = SHIFT;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign w_d = {w_sh_n, w_po_n, w_cnt_n, w_pv_n, w_ferr_n, w_state_n};

`ifdef SAMPLE_DESER_CELLS_EN
  for (genvar g = 0; g < NFF; g++) begin : g_ff
    dffrx1 u_ff (
      .CK (CK),
      .RB (RB),
      .D  (w_d[g]),
      .Q  (r_q[g])
    );
  end
`else
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      r_q <= '0;
    end else begin
      r_q <= w_d;
    end
  end
`endif

endmodule

// File: tb/tb_sample_deser.sv
// Directed bench for sample_deser: MSB-first and LSB-first instances share one stimulus stream.
module tb_sample_deser;

  logic       CK   = 1'b0;
  logic       RB   = 1'b0;
  logic       SI   = 1'b0;
  logic       SV   = 1'b0;
  logic       SYNC = 1'b0;
  logic       PR   = 1'b0;

  logic       srdy_m, pv_m, ferr_m;
  logic [7:0] po_m;
  logic       srdy_l, pv_l, ferr_l;
  logic [7:0] po_l;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_xfer = 0;

  sample_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CK(CK), .RB(RB), .SI(SI), .SV(SV), .SYNC(SYNC),
    .SRDY(srdy_m), .PO(po_m), .PV(pv_m), .PR(PR), .FERR(ferr_m)
  );

  sample_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .CK(CK), .RB(RB), .SI(SI), .SV(SV), .SYNC(SYNC),
    .SRDY(srdy_l), .PO(po_l), .PV(pv_l), .PR(PR), .FERR(ferr_l)
  );

  always #5 CK = ~CK;

  // Count FERR pulses and completed handshakes of the MSB-first instance
  always @(posedge CK) begin
    if (RB) begin
      if (ferr_m) n_ferr <= n_ferr + 1;
      if (pv_m && PR) n_xfer <= n_xfer + 1;
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic send_bit(input logic s, input logic b);
    SV = 1'b1; SYNC = s; SI = b;
    tick();
    SV = 1'b0; SYNC = 1'b0;
  endtask

  // First serial bit is w[7] and carries SYNC
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(i == 7, w[i]);
  endtask

  task automatic send_raw(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, w[i]);
  endtask

  task automatic test_reset();
    #12;
    checks++; if (po_m !== 8'h00) begin errors++; $display("FAIL reset_po got %h want 00", po_m); end
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL reset_pv got %b want 0", pv_m); end
    checks++; if (srdy_m !== 1'b1) begin errors++; $display("FAIL reset_srdy got %b want 1", srdy_m); end
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", ferr_m); end
    @(negedge CK);
    RB = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    PR = 1'b1;
    send_word(8'hA5);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL basic_pv got %b want 1", pv_m); end
    checks++; if (po_m !== 8'hA5) begin errors++; $display("FAIL basic_po got %h want a5", po_m); end
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b want 0", ferr_m); end
    checks++; if (po_l !== 8'hA5) begin errors++; $display("FAIL basic_po_lsb got %h want a5", po_l); end
    tick();
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL basic_pv_drop got %b want 0", pv_m); end
  endtask

  task automatic test_bit_order();
    send_word(8'hC0);
    checks++; if (po_l !== 8'h03) begin errors++; $display("FAIL order_lsb got %h want 03", po_l); end
    checks++; if (pv_l !== 1'b1) begin errors++; $display("FAIL order_pv_lsb got %b want 1", pv_l); end
    checks++; if (po_m !== 8'hC0) begin errors++; $display("FAIL order_msb got %h want c0", po_m); end
    tick();
  endtask

  task automatic test_backpressure();
    PR = 1'b0;
    send_word(8'h3C);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL bp_w1_pv got %b want 1", pv_m); end
    checks++; if (po_m !== 8'h3C) begin errors++; $display("FAIL bp_w1_po got %h want 3c", po_m); end
    checks++; if (srdy_m !== 1'b1) begin errors++; $display("FAIL bp_w1_srdy got %b want 1", srdy_m); end
    send_word(8'hF0);
    checks++; if (srdy_m !== 1'b0) begin errors++; $display("FAIL bp_stall_srdy got %b want 0", srdy_m); end
    checks++; if (po_m !== 8'h3C) begin errors++; $display("FAIL bp_stall_po got %h want 3c", po_m); end
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL bp_stall_pv got %b want 1", pv_m); end
    SV = 1'b1; SI = 1'b1;
    tick(); tick();
    SV = 1'b0;
    checks++; if (srdy_m !== 1'b0) begin errors++; $display("FAIL bp_hold_srdy got %b want 0", srdy_m); end
    checks++; if (po_m !== 8'h3C) begin errors++; $display("FAIL bp_hold_po got %h want 3c", po_m); end
    PR = 1'b1;
    tick();
    checks++; if (po_m !== 8'hF0) begin errors++; $display("FAIL bp_release_po got %h want f0", po_m); end
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL bp_release_pv got %b want 1", pv_m); end
    checks++; if (srdy_m !== 1'b1) begin errors++; $display("FAIL bp_release_srdy got %b want 1", srdy_m); end
    checks++; if (po_l !== 8'h0F) begin errors++; $display("FAIL bp_release_po_lsb got %h want 0f", po_l); end
    tick();
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL bp_drain_pv got %b want 0", pv_m); end
  endtask

  task automatic test_frame_abort();
    int base_ferr;
    int base_xfer;
    logic [7:0] w;
    w = 8'h81;
    PR = 1'b1;
    base_ferr = n_ferr;
    base_xfer = n_xfer;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    checks++; if (ferr_m !== 1'b0) begin errors++; $display("FAIL abort_pre_ferr got %b want 0", ferr_m); end
    send_bit(1'b1, w[7]);
    checks++; if (ferr_m !== 1'b1) begin errors++; $display("FAIL abort_ferr got %b want 1", ferr_m); end
    checks++; if (ferr_l !== 1'b1) begin errors++; $display("FAIL abort_ferr_lsb got %b want 1", ferr_l); end
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL abort_pv got %b want 0", pv_m); end
    for (int i = 6; i >= 0; i--) begin
      send_bit(1'b0, w[i]);
      if (i == 6) begin
        checks++; if (ferr_m !== 1'b0) begin errors++; $display("FAIL abort_ferr_clear got %b want 0", ferr_m); end
      end
    end
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL abort_word_pv got %b want 1", pv_m); end
    checks++; if (po_m !== 8'h81) begin errors++; $display("FAIL abort_word_po got %h want 81", po_m); end
    checks++; if (po_l !== 8'h81) begin errors++; $display("FAIL abort_word_po_lsb got %h want 81", po_l); end
    tick();
    checks++; if (n_ferr - base_ferr != 1) begin errors++; $display("FAIL abort_ferr_count got %0d want 1", n_ferr - base_ferr); end
    checks++; if (n_xfer - base_xfer != 1) begin errors++; $display("FAIL abort_xfer_count got %0d want 1", n_xfer - base_xfer); end
  endtask

  task automatic test_idle_filter();
    int base_xfer;
    #2 RB = 1'b0;
    @(negedge CK);
    RB = 1'b1;
    tick();
    PR = 1'b1;
    base_xfer = n_xfer;
    SYNC = 1'b1; SV = 1'b0;
    tick();
    SYNC = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
    send_raw(8'hFF);
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL idle_pv got %b want 0", pv_m); end
    checks++; if (n_xfer != base_xfer) begin errors++; $display("FAIL idle_xfer got %0d want %0d", n_xfer, base_xfer); end
    send_word(8'h55);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL idle_word_pv got %b want 1", pv_m); end
    checks++; if (po_m !== 8'h55) begin errors++; $display("FAIL idle_word_po got %h want 55", po_m); end
    checks++; if (po_l !== 8'hAA) begin errors++; $display("FAIL idle_word_po_lsb got %h want aa", po_l); end
    tick();
  endtask

  task automatic test_reset_mid();
    PR = 1'b0;
    send_word(8'h12);
    send_word(8'h34);
    checks++; if (srdy_m !== 1'b0) begin errors++; $display("FAIL rmid_stall_srdy got %b want 0", srdy_m); end
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL rmid_stall_pv got %b want 1", pv_m); end
    #2 RB = 1'b0;
    #1;
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL rmid_pv got %b want 0", pv_m); end
    checks++; if (po_m !== 8'h00) begin errors++; $display("FAIL rmid_po got %h want 00", po_m); end
    checks++; if (srdy_m !== 1'b1) begin errors++; $display("FAIL rmid_srdy got %b want 1", srdy_m); end
    checks++; if (srdy_l !== 1'b1) begin errors++; $display("FAIL rmid_srdy_lsb got %b want 1", srdy_l); end
    @(negedge CK);
    RB = 1'b1;
    tick();
    PR = 1'b1;
    send_raw(8'hFF);
    checks++; if (pv_m !== 1'b0) begin errors++; $display("FAIL rmid_nosync_pv got %b want 0", pv_m); end
    send_word(8'hA5);
    checks++; if (pv_m !== 1'b1) begin errors++; $display("FAIL rmid_word_pv got %b want 1", pv_m); end
    checks++; if (po_m !== 8'hA5) begin errors++; $display("FAIL rmid_word_po got %h want a5", po_m); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_order();
    test_backpressure();
    test_frame_abort();
    test_idle_filter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
